mul_sequencer: RTL and testbench

Iterative shift-add multiply sequencer that executes MUL/MLA on the shared barrel shifter and ALU rather than on a dedicated multiplier. The main controller hands it operands and a start strobe. It walks the multiplier bits, requesting the shared shifter/ALU path once per set bit and accumulating the sum in a private register. It returns a 32-bit result plus optional N/Z flag updates for the register-file writeback.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/mul_sequencer.sv | 130 +++++++++++++
 tb/tb_mul_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU/shifter opcodes and the multiply sequencer state type.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package cpu_pkg;

  // Opcodes on the shared shifter/ALU path, also driven by the main controller.
  localparam logic [3:0] ALU_OP_ADD   = 4'b0100;
  localparam logic [2:0] SHIFT_OP_LSL = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_sequencer.sv
// Shift-add MUL/MLA sequencer borrowing the shared barrel shifter + ALU, one add per set multiplier bit.
// Latency: done in cycle 2+p after start (p = highest set bit index + 1, 0 for a zero multiplier), +1 per ungranted request.
// Backpressure: a low alu_gnt while requesting freezes every register; start is ignored while busy.
//
// Ports:
//   clk, rst (async, active low)
//   start/is_mla/set_flags/rm_val/rs_val/rn_val : operation launch, sampled in IDLE only
//   flush                                      : synchronous abort to IDLE, no done
//   busy/done/result/flag_we/flag_n/flag_z     : status and writeback
//   alu_req/alu_gnt                            : shared shifter/ALU arbitration (same-cycle grant)
//   sh_data/sh_num/sh_op/alu_a/alu_op/alu_s    : operands for the shared path, driven continuously
//   alu_f                                      : ALU result, combinational from the driven operands
module mul_sequencer
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32  // only 32 is supported
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_mla,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] rm_val,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rn_val,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_we,
  output logic             flag_n,
  output logic             flag_z,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [WIDTH-1:0] sh_data,
  output logic [7:0]       sh_num,
  output logic [2:0]       sh_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [3:0]       alu_op,
  output logic             alu_s,
  input  logic [WIDTH-1:0] alu_f
);

  mul_state_t       state_q,  state_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [4:0]       cnt_q,    cnt_d;
  logic             sflag_q,  sflag_d;

  logic mplier_zero;
  assign mplier_zero = (mplier_q == '0);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    sflag_d  = sflag_q;
    if (flush) begin
      // Abort wins over everything, including a start in IDLE; acc is deliberately left stale.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_d  = rm_val;
            mplier_d = rs_val;
            cnt_d    = '0;
            sflag_d  = set_flags;
            acc_d    = is_mla ? rn_val : '0;
            state_d  = RUN;
          end
        end
        RUN: begin
          if (mplier_zero) begin
            state_d = DONE;
          end else if (!mplier_q[0]) begin
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
          end else if (alu_gnt) begin
            // alu_f = acc + (mcand << cnt), computed on the shared path.
            acc_d    = alu_f;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
          end
          // Set bit without a grant: everything holds and the request repeats next cycle.
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      sflag_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      sflag_q  <= sflag_d;
    end
  end

  // All outputs decode registered state only, so no input-to-output combinational path exists.
  assign busy    = (state_q == RUN) || (state_q == DONE);
  assign done    = (state_q == DONE);
  assign result  = acc_q;
  assign flag_we = done && sflag_q;
  assign flag_n  = acc_q[WIDTH-1];
  assign flag_z  = (acc_q == '0);

  assign alu_req = (state_q == RUN) && mplier_q[0] && !mplier_zero;
  assign sh_data = mcand_q;
  assign sh_num  = {3'b000, cnt_q};
  assign sh_op   = SHIFT_OP_LSL;
  assign alu_a   = acc_q;
  assign alu_op  = ALU_OP_ADD;
  assign alu_s   = 1'b0;

endmodule

// File: tb/tb_mul_sequencer.sv
module tb_mul_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, is_mla = 1'b0, set_flags = 1'b0, flush = 1'b0;
  logic [31:0] rm_val = '0, rs_val = '0, rn_val = '0;
  logic        alu_gnt = 1'b1;
  logic        busy, done, flag_we, flag_n, flag_z, alu_req, alu_s;
  logic [31:0] result, sh_data, alu_a, alu_f;
  logic [7:0]  sh_num;
  logic [2:0]  sh_op;
  logic [3:0]  alu_op;

  always #5 clk = ~clk;

  // Environment: the shared shifter + ALU performing LSL then ADD.
  assign alu_f = alu_a + (sh_data << sh_num);

  mul_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_mla(is_mla), .set_flags(set_flags),
    .rm_val(rm_val), .rs_val(rs_val), .rn_val(rn_val), .flush(flush),
    .busy(busy), .done(done), .result(result), .flag_we(flag_we),
    .flag_n(flag_n), .flag_z(flag_z), .alu_req(alu_req), .alu_gnt(alu_gnt),
    .sh_data(sh_data), .sh_num(sh_num), .sh_op(sh_op), .alu_a(alu_a),
    .alu_op(alu_op), .alu_s(alu_s), .alu_f(alu_f)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- Behavioural model ----------------
  // Operation is described by its operands and how many multiplier bits have been consumed (m_idx).
  // The accumulator is then base + rm * (rs restricted to the consumed bits), modulo 2^32.
  int          m_ph;    // 0 idle, 1 running, 2 done
  logic [31:0] m_base, m_rm, m_rs;
  logic        m_s;
  int          m_idx;

  initial begin
    int          n_ph, n_idx;
    logic [31:0] n_base, n_rm, n_rs;
    logic        n_s;
    logic [63:0] rem;
    logic [31:0] e_acc;
    logic        e_req;
    m_ph = 0; m_base = '0; m_rm = '0; m_rs = '0; m_s = 1'b0; m_idx = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_ph = 0; m_base = '0; m_rm = '0; m_rs = '0; m_s = 1'b0; m_idx = 0;
      end
      rem   = {32'b0, m_rs} >> m_idx;
      e_acc = m_base + 32'({32'b0, m_rm} * ({32'b0, m_rs} & ((64'd1 << m_idx) - 64'd1)));
      e_req = (m_ph == 1) && (rem != 64'd0) && rem[0];
      chk("busy",    {31'b0, busy},    {31'b0, m_ph != 0});
      chk("done",    {31'b0, done},    {31'b0, m_ph == 2});
      chk("result",  result,           e_acc);
      chk("flag_we", {31'b0, flag_we}, {31'b0, (m_ph == 2) && m_s});
      chk("flag_n",  {31'b0, flag_n},  {31'b0, e_acc[31]});
      chk("flag_z",  {31'b0, flag_z},  {31'b0, e_acc == 32'd0});
      chk("alu_req", {31'b0, alu_req}, {31'b0, e_req});
      chk("sh_data", sh_data,          m_rm);
      chk("sh_num",  {24'b0, sh_num},  32'(m_idx % 32));
      chk("alu_a",   alu_a,            e_acc);
      chk("consts",  {24'b0, alu_s, sh_op, alu_op}, {24'b0, 1'b0, SHIFT_OP_LSL, ALU_OP_ADD});
      n_ph = m_ph; n_idx = m_idx; n_base = m_base; n_rm = m_rm; n_rs = m_rs; n_s = m_s;
      if (flush) n_ph = 0;
      else if (m_ph == 0) begin
        if (start) begin
          n_ph = 1; n_idx = 0; n_rm = rm_val; n_rs = rs_val; n_s = set_flags;
          n_base = is_mla ? rn_val : 32'd0;
        end
      end else if (m_ph == 1) begin
        if (rem == 64'd0) n_ph = 2;
        else if (!rem[0] || alu_gnt) n_idx = m_idx + 1;
      end else n_ph = 0;
      @(posedge clk);
      if (rst) begin
        m_ph = n_ph; m_idx = n_idx; m_base = n_base; m_rm = n_rm; m_rs = n_rs; m_s = n_s;
      end
    end
  end

  // ---------------- Directed stimulus ----------------
  // Cycle 0 is the cycle start is presented in; done is expected in cycle 2+p.
  task automatic do_op(input logic mla, input logic s, input logic [31:0] rm, input logic [31:0] rs,
                       input logic [31:0] rn, input int gnt_low, output int cyc,
                       output logic [31:0] res, output logic fwe, output logic fn,
                       output logic fz, output int nreq);
    bit got;
    @(posedge clk); #1;
    start = 1'b1; is_mla = mla; set_flags = s; rm_val = rm; rs_val = rs; rn_val = rn;
    alu_gnt = (gnt_low > 0) ? 1'b0 : 1'b1;
    cyc = 0; nreq = 0; got = 0; res = '0; fwe = 0; fn = 0; fz = 0;
    while (!got && cyc < 60) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      alu_gnt = (cyc < gnt_low) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (alu_req) nreq++;
      if (done) begin
        got = 1; res = result; fwe = flag_we; fn = flag_n; fz = flag_z;
      end
    end
    chk("done_seen", {31'b0, got}, 32'd1);
  endtask

  task automatic launch(input logic [31:0] rm, input logic [31:0] rs);
    @(posedge clk); #1;
    start = 1'b1; is_mla = 1'b0; set_flags = 1'b0; rm_val = rm; rs_val = rs;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int          cyc, nreq;
    logic [31:0] res;
    logic        fwe, fn, fz;

    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy",   {31'b0, busy},   32'd0);
    chk("rst_flag_z", {31'b0, flag_z}, 32'd1);
    chk("rst_result", result,          32'd0);
    rst = 1'b1;

    // MUL 7*6
    do_op(0, 0, 32'd7, 32'd6, 32'd0, 0, cyc, res, fwe, fn, fz, nreq);
    chk("mul76_cyc", 32'(cyc), 32'd5);
    chk("mul76_res", res, 32'd42);
    chk("mul76_req", 32'(nreq), 32'd2);
    chk("mul76_fwe", {31'b0, fwe}, 32'd0);

    // MLA with zero multiplier, issued back-to-back
    do_op(1, 0, 32'd3, 32'd0, 32'd100, 0, cyc, res, fwe, fn, fz, nreq);
    chk("mla0_cyc", 32'(cyc), 32'd2);
    chk("mla0_res", res, 32'd100);
    chk("mla0_req", 32'(nreq), 32'd0);

    // MUL S=1, longest multiplier
    do_op(0, 1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0, cyc, res, fwe, fn, fz, nreq);
    chk("mulmax_cyc", 32'(cyc), 32'd34);
    chk("mulmax_res", res, 32'h8000_0000);
    chk("mulmax_fwe", {31'b0, fwe}, 32'd1);
    chk("mulmax_fn",  {31'b0, fn},  32'd1);
    chk("mulmax_fz",  {31'b0, fz},  32'd0);

    // 5*5 with grant withheld for the first three cycles (two of them while requesting)
    do_op(0, 0, 32'd5, 32'd5, 32'd0, 3, cyc, res, fwe, fn, fz, nreq);
    chk("stall_cyc", 32'(cyc), 32'd7);
    chk("stall_res", res, 32'd25);

    // MLA 3*4+10
    do_op(1, 1, 32'd3, 32'd4, 32'd10, 0, cyc, res, fwe, fn, fz, nreq);
    chk("mla_cyc", 32'(cyc), 32'd5);
    chk("mla_res", res, 32'd22);
    chk("mla_fz",  {31'b0, fz}, 32'd0);

    // Flush in cycle 3, with an ignored start while busy in cycle 2
    launch(32'd2, 32'h0000_00FF);
    @(posedge clk); #1;
    start = 1'b1; rm_val = 32'd1; rs_val = 32'd1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_done", {31'b0, done}, 32'd0);
    // flush and start together in IDLE: start dropped
    start = 1'b1; flush = 1'b1; rm_val = 32'd4; rs_val = 32'd4;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flushstart_busy", {31'b0, busy}, 32'd0);
    do_op(0, 0, 32'd9, 32'd9, 32'd0, 0, cyc, res, fwe, fn, fz, nreq);
    chk("postflush_cyc", 32'(cyc), 32'd6);
    chk("postflush_res", res, 32'd81);

    // Asynchronous reset in cycle 4 of a long multiply
    launch(32'd3, 32'hFFFF_0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("arst_busy",    {31'b0, busy},    32'd0);
    chk("arst_result",  result,           32'd0);
    chk("arst_flag_z",  {31'b0, flag_z},  32'd1);
    chk("arst_alu_req", {31'b0, alu_req}, 32'd0);
    chk("arst_sh_data", sh_data,          32'd0);
    chk("arst_sh_num",  {24'b0, sh_num},  32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    do_op(0, 0, 32'd6, 32'd7, 32'd0, 0, cyc, res, fwe, fn, fz, nreq);
    chk("postrst_cyc", 32'(cyc), 32'd5);
    chk("postrst_res", res, 32'd42);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
